// File: rtl/rv32i_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32i_mem_arbiter_if                                         |
// | Description : Fetch, load/store and RAM bus bundle for rv32i_mem_arbiter.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [15:0]       conflict_cnt;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );

  // Core and RAM side
  modport master (
    output if_req_valid, if_addr, d_req_valid, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32i_mem_arbiter                                            |
// | Description : Shares one single-port RAM between fetch and load/store,     |
// |               data-priority with a bounded streak to avoid fetch starving. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module rv32i_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int MAX_STREAK = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rv32i_mem_arbiter_if.slave bus
);

  localparam logic [3:0]  c_maxStreak = 4'(MAX_STREAK);
  localparam logic [15:0] c_cntMax    = 16'hFFFF;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_t;

  owner_t      r_owner;
  logic [3:0]  r_streak;
  logic [15:0] r_conflictCnt;
  logic [31:0] r_ifRspData;
  logic [31:0] r_dRspData;

  logic w_grantIf;
  logic w_grantD;
  logic w_store;
  logic w_unusedLowBits;

  // Ready depends only on requests and the streak, never on responses.
  always_comb begin
    w_grantD  = bus.d_req_valid & ~(bus.if_req_valid & (r_streak == c_maxStreak));
    w_grantIf = bus.if_req_valid & ~w_grantD;
    w_store   = w_grantD & bus.d_we;
  end

  assign w_unusedLowBits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  assign bus.if_req_ready = w_grantIf;
  assign bus.d_req_ready  = w_grantD;

  assign bus.mem_en    = w_grantIf | w_grantD;
  assign bus.mem_we    = w_store ? bus.d_wstrb : 4'b0000;
  assign bus.mem_wdata = w_store ? bus.d_wdata : 32'd0;
  assign bus.mem_addr  = w_grantD  ? bus.d_addr[ADDR_W-1:2]  :
                         w_grantIf ? bus.if_addr[ADDR_W-1:2] : '0;

  assign bus.if_rsp_valid = (r_owner == OWN_IF);
  assign bus.d_rsp_valid  = (r_owner == OWN_DRD) | (r_owner == OWN_DWR);

  // RAM data appears during the response cycle; the hold registers keep it afterwards.
  assign bus.if_rsp_data = (r_owner == OWN_IF)  ? bus.mem_rdata : r_ifRspData;
  assign bus.d_rsp_data  = (r_owner == OWN_DRD) ? bus.mem_rdata :
                           (r_owner == OWN_DWR) ? 32'd0         : r_dRspData;

  assign bus.conflict_cnt = r_conflictCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner       <= OWN_NONE;
      r_streak      <= 4'd0;
      r_conflictCnt <= 16'd0;
      r_ifRspData   <= 32'd0;
      r_dRspData    <= 32'd0;
    end else begin
      case (r_owner)
        OWN_IF:  r_ifRspData <= bus.mem_rdata;
        OWN_DRD: r_dRspData  <= bus.mem_rdata;
        OWN_DWR: r_dRspData  <= 32'd0;
        default: ;
      endcase

      if (w_grantIf) begin
        r_owner <= OWN_IF;
      end else if (w_grantD) begin
        r_owner <= bus.d_we ? OWN_DWR : OWN_DRD;
      end else begin
        r_owner <= OWN_NONE;
      end

      if (w_grantIf || !bus.if_req_valid) begin
        r_streak <= 4'd0;
      end else if (w_grantD && (r_streak != c_maxStreak)) begin
        r_streak <= r_streak + 4'd1;
      end

      if (bus.if_req_valid && bus.d_req_valid && (r_conflictCnt != c_cntMax)) begin
        r_conflictCnt <= r_conflictCnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
